// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encoding,
// data access size codes and the default fetch starvation bound.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIfAcc   = 2'd1,
        StDAcc    = 2'd2,
        StDrained = 2'd3
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants issued while fetch was waiting.
module arb_starve_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CntW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == CntW'(MAX));

    // Clear has priority so a fetch grant always restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory, bounding fetch starvation and supporting a drain/quiesce handshake.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [ADDR_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              drain,
    output logic              quiesced
);

    arb_state_e        state_q, state_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    logic [ADDR_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d, lat_wdata_q, lat_wdata_d;
    logic              lat_we_q, lat_we_d;
    logic [1:0]        lat_size_q, lat_size_d;

    logic in_idle, if_eff, d_eff, d_win, arb_en;
    logic starve_inc, starve_clr, starve_sat;

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    // A requester that is still seeing its completion pulse in IDLE is not yet
    // presenting a new request, so it is masked for that cycle.
    assign in_idle = (state_q == StIdle);
    assign if_eff  = if_req && !(in_idle && if_valid_q);
    assign d_eff   = d_req && !(in_idle && d_valid_q);
    assign d_win   = d_eff && (!starve_sat || !if_eff);

    always_comb begin
        state_d     = state_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_we_d    = lat_we_q;
        lat_size_d  = lat_size_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;
        arb_en      = 1'b0;

        unique case (state_q)
            StIdle: arb_en = 1'b1;
            StIfAcc: begin
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    arb_en     = 1'b1;
                end
            end
            StDAcc: begin
                if (mem_ready) begin
                    if (!lat_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_valid_d = 1'b1;
                    arb_en    = 1'b1;
                end
            end
            StDrained: begin
                if (!drain) begin
                    state_d = StIdle;
                end
            end
        endcase

        // Drain passes through IDLE so the completion pulse lands before quiesced.
        if (arb_en) begin
            if (drain) begin
                state_d = in_idle ? StDrained : StIdle;
            end else if (d_win) begin
                state_d     = StDAcc;
                d_gnt_d     = 1'b1;
                lat_addr_d  = d_addr;
                lat_wdata_d = d_wdata;
                lat_we_d    = d_we;
                lat_size_d  = d_size;
                starve_inc  = if_eff;
                starve_clr  = !if_eff;
            end else if (if_eff) begin
                state_d     = StIfAcc;
                if_gnt_d    = 1'b1;
                lat_addr_d  = if_addr;
                lat_wdata_d = '0;
                lat_we_d    = 1'b0;
                lat_size_d  = SZ_WORD;
                starve_clr  = 1'b1;
            end else begin
                state_d    = StIdle;
                starve_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_we_q    <= 1'b0;
            lat_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_we_q    <= lat_we_d;
            lat_size_q  <= lat_size_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = (state_q == StIfAcc) || (state_q == StDAcc);
    assign mem_we    = lat_we_q && (state_q == StDAcc);
    assign mem_size  = lat_size_q;
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;
    assign quiesced  = (state_q == StDrained);

endmodule
